// File: rtl/fnd_display_arbiter.sv
// fnd_display_arbiter
//   Shares one 4-digit FND driver among four value sources. Grants the
//   display round-robin with a minimum dwell per owner (in prescaled ticks)
//   and forwards the owner's 16-bit word to the driver's value input.
//
// Parameters
//   TICK_DIV : clk cycles per dwell tick (>= 2)
//   HOLD_MS  : minimum dwell in ticks before rotating (>= 1)
//
// Ports
//   clk      : system clock, rising edge
//   reset_p  : synchronous active-high reset
//   req      : per-source level request
//   values   : source n word on bits [16n+15:16n]
//   value    : registered word for the FND driver
//   grant    : registered one-hot owner, 0 when idle
//   blank    : registered, 1 when no source owns the display
//   switch_p : one-cycle pulse when grant takes a new nonzero value
//
// Build option
//   FND_ARB_PREEMPT_EN : source 0 becomes urgent and preempts the rotation.
module fnd_display_arbiter #(
  parameter int unsigned TICK_DIV = 100_000,
  parameter int unsigned HOLD_MS  = 2000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [3:0]  req,
  input  logic [63:0] values,
  output logic [15:0] value,
  output logic [3:0]  grant,
  output logic        blank,
  output logic        switch_p
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_MS + 1);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [1:0]     last_q, last_d;
  logic [1:0]     own_q, own_d;
  logic [15:0]    value_q, value_d;
  logic [3:0]     grant_q, grant_d;
  logic           blank_q, blank_d;
  logic           switch_q, switch_d;

  logic           tick;
  logic [HW-1:0]  hold_next;
  logic [3:0]     others;
  logic           owner_req;
  logic           preempt_hit;
  logic           rot_block;
  logic           move;
  logic [1:0]     target;

  // First asserted request in the order from+1, from+2, from+3, from.
  function automatic logic [1:0] rr_pick(input logic [1:0] from,
                                         input logic [3:0] r);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = from;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [15:0] word_of(input logic [63:0] v,
                                          input logic [1:0]  sel);
    return v[{sel, 4'b0000} +: 16];
  endfunction

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign hold_next = (tick && hold_q != HW'(HOLD_MS)) ? hold_q + HW'(1) : hold_q;
  assign others    = req & ~grant_q;
  assign owner_req = req[own_q];

`ifdef FND_ARB_PREEMPT_EN
  // Urgent source 0 takes over without touching the rotation pointer, and
  // while it holds the display with its request up it is never rotated out.
  assign preempt_hit = req[0] && (own_q != 2'd0);
  assign rot_block   = (own_q == 2'd0);
`else
  assign preempt_hit = 1'b0;
  assign rot_block   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    hold_d   = hold_q;
    last_d   = last_q;
    own_d    = own_q;
    value_d  = value_q;
    grant_d  = grant_q;
    blank_d  = blank_q;
    move     = 1'b0;
    target   = own_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        blank_d = 1'b1;
        value_d = '0;
        hold_d  = '0;
        if (|req) begin
          move    = 1'b1;
          target  = rr_pick(last_q, req);
          last_d  = target;
          state_d = SHOW;
        end
      end

      SHOW: begin
        hold_d = hold_next;
        if (preempt_hit) begin
          move   = 1'b1;
          target = 2'd0;
        end else if (!owner_req && (|others)) begin
          move   = 1'b1;
          target = rr_pick(last_q, others);
          last_d = target;
        end else if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
          blank_d = 1'b1;
          value_d = '0;
          hold_d  = '0;
        end else if ((hold_q == HW'(HOLD_MS)) && (|others) && !rot_block) begin
          move   = 1'b1;
          target = rr_pick(last_q, others);
          last_d = target;
        end else begin
          value_d = word_of(values, own_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (move) begin
      own_d   = target;
      grant_d = 4'b0001 << target;
      blank_d = 1'b0;
      value_d = word_of(values, target);
      hold_d  = '0;
    end

    switch_d = (grant_d != 4'b0000) && (grant_d != grant_q);
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      hold_q   <= '0;
      last_q   <= 2'd3;
      own_q    <= 2'd0;
      value_q  <= '0;
      grant_q  <= '0;
      blank_q  <= 1'b1;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      own_q    <= own_d;
      value_q  <= value_d;
      grant_q  <= grant_d;
      blank_q  <= blank_d;
      switch_q <= switch_d;
    end
  end

  assign value    = value_q;
  assign grant    = grant_q;
  assign blank    = blank_q;
  assign switch_p = switch_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed bench for fnd_display_arbiter with TICK_DIV=4, HOLD_MS=3.
// Edge E_k is the k-th clock edge after reset release; outputs are sampled
// 1 time unit after each edge.
module tb_fnd_display_arbiter;

  logic        clk;
  logic        reset_p;
  logic [3:0]  req;
  logic [63:0] values;
  logic [15:0] value;
  logic [3:0]  grant;
  logic        blank;
  logic        switch_p;

  int errors;
  int checks;

  fnd_display_arbiter #(
    .TICK_DIV(4),
    .HOLD_MS (3)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .req     (req),
    .values  (values),
    .value   (value),
    .grant   (grant),
    .blank   (blank),
    .switch_p(switch_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    step(1);
    reset_p = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_p = 1'b1;
    req     = 4'b1111;
    values  = {16'h9ABC, 16'h5678, 16'h1234, 16'hA0A0};

    // 1. reset with all requesting
    step(2);
    check("rst_grant", {12'd0, grant}, 16'h0000);
    check("rst_blank", {15'd0, blank}, 16'h0001);
    check("rst_value", value, 16'h0000);
    check("rst_switch", {15'd0, switch_p}, 16'h0000);
    reset_p = 1'b0;
    step(1);
    check("first_grant", {12'd0, grant}, 16'h0001);
    check("first_switch", {15'd0, switch_p}, 16'h0001);
    check("first_value", value, 16'hA0A0);
    check("first_blank", {15'd0, blank}, 16'h0000);
    step(1);
    check("first_switch_off", {15'd0, switch_p}, 16'h0000);

    // 2. rotation between sources 1 and 2
    req = 4'b0110;
    do_reset();
    step(1);  // E1
    check("rot_g1", {12'd0, grant}, 16'h0002);
    check("rot_v1", value, 16'h1234);
    step(11); // E12: hold just reached 3
    check("rot_dwell1", {12'd0, grant}, 16'h0002);
    check("rot_nosw", {15'd0, switch_p}, 16'h0000);
    step(1);  // E13
    check("rot_g2", {12'd0, grant}, 16'h0004);
    check("rot_v2", value, 16'h5678);
    check("rot_sw2", {15'd0, switch_p}, 16'h0001);
    step(11); // E24
    check("rot_dwell2", {12'd0, grant}, 16'h0004);
    step(1);  // E25
    check("rot_back", {12'd0, grant}, 16'h0002);
    check("rot_back_v", value, 16'h1234);

    // 3. owner drop with competitor, then drop all
    req = 4'b1000;
    step(1);
    check("drop_grant", {12'd0, grant}, 16'h0008);
    check("drop_value", value, 16'h9ABC);
    check("drop_switch", {15'd0, switch_p}, 16'h0001);
    req = 4'b0000;
    step(1);
    check("idle_grant", {12'd0, grant}, 16'h0000);
    check("idle_blank", {15'd0, blank}, 16'h0001);
    check("idle_value", value, 16'h0000);

    // 4. live update of the owner's word
    values[47:32] = 16'h0001;
    req = 4'b0100;
    do_reset();
    step(1);
    check("live_grant", {12'd0, grant}, 16'h0004);
    check("live_v1", value, 16'h0001);
    values[47:32] = 16'h0002;
    step(1);
    check("live_v2", value, 16'h0002);
    check("live_nosw", {15'd0, switch_p}, 16'h0000);

    // 5. sole requester keeps the display
    for (int i = 0; i < 40; i++) begin
      step(1);
      check("sole_grant", {12'd0, grant}, 16'h0004);
      check("sole_nosw", {15'd0, switch_p}, 16'h0000);
    end

    // 6. urgent source 0 while source 2 owns and source 3 waits
    values[47:32] = 16'h5678;
    req = 4'b0100;
    do_reset();
    step(1);  // E1
    check("pre_own", {12'd0, grant}, 16'h0004);
    req = 4'b1100;
    step(1);  // E2
    req = 4'b1101;
    step(1);  // E3
`ifdef FND_ARB_PREEMPT_EN
    check("pre_take", {12'd0, grant}, 16'h0001);
    check("pre_take_v", value, 16'hA0A0);
    check("pre_take_sw", {15'd0, switch_p}, 16'h0001);
    step(14); // E17: hold long saturated
    check("pre_keep", {12'd0, grant}, 16'h0001);
    req = 4'b1100;
    step(1);
    check("pre_resume", {12'd0, grant}, 16'h0008);
    check("pre_resume_v", value, 16'h9ABC);
`else
    check("nopre_stay", {12'd0, grant}, 16'h0004);
    req = 4'b1100;
    step(9);  // E12
    check("nopre_dwell", {12'd0, grant}, 16'h0004);
    step(1);  // E13
    check("nopre_rot", {12'd0, grant}, 16'h0008);
    check("nopre_rot_v", value, 16'h9ABC);
`endif

    // reset in the middle of operation
    reset_p = 1'b1;
    step(1);
    check("mid_rst_grant", {12'd0, grant}, 16'h0000);
    check("mid_rst_blank", {15'd0, blank}, 16'h0001);
    check("mid_rst_sw", {15'd0, switch_p}, 16'h0000);
    reset_p = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnd_display_arbiter.md
# fnd_display_arbiter

Shares the single 4-digit FND display driver among four independent value sources, such as fan speed, timer and temperature. It grants the display to one requester at a time in round-robin order, with a minimum dwell time per source, and presents the granted source's 16-bit BCD/hex word to the FND driver's `value` input. An optional urgent channel (source 0) can preempt the rotation. The block sits between the application modules and the FND driver.

## Interface
- `TICK_DIV`, default 100_000: clk cycles per dwell tick (1 ms at 100 MHz); must be ≥2.
- `HOLD_MS`, default 2000: minimum dwell, in ticks, before rotating to another requester; must be ≥1.
- `clk` input 1: system clock; all logic on rising edge.
- `reset_p` input 1: synchronous, active-high reset.
- `req` input 4: per-source display request, level-sensitive.
- `values` input 64: source n's word on bits [16n+15:16n].
- `value` output 16: word for the FND driver; registered.
- `grant` output 4: one-hot owner of the display; 0 when idle; registered.
- `blank` output 1: 1 when no source owns the display; registered.
- `switch_p` output 1: one-cycle pulse on every cycle in which `grant` takes a new nonzero value.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. `tick` is asserted in the cycle the count equals TICK_DIV-1.
- `last` is a 2-bit round-robin pointer and resets to 3. The search order is `last`+1, `last`+2, … mod 4, and the first asserted `req` wins.
- States:
  - IDLE: `grant`=0, `blank`=1, `value`=0. If any `req` is asserted, the next edge loads `grant` from the search, sets `last` to the winner, clears `hold`, and moves to SHOW.
  - SHOW: `value` <= selected word from `values` for `grant` every cycle, so the source may update live. `hold` increments on `tick` and saturates at HOLD_MS.
- SHOW transitions, evaluated in priority order each cycle:
  1. Preempt: macro only; see Configuration.
  2. If the granted `req` is low and another `req` is high, re-search from `last` with no hold wait.
  3. If the granted `req` is low and no `req` is high, go to IDLE: `grant`=0, `blank`=1, `value`=0. `last` is kept.
  4. If `hold`==HOLD_MS and another `req` is high, rotate by searching from `last`.
  5. Otherwise stay. With only the owner requesting, it keeps the display indefinitely.
- Every grant change clears `hold` and loads `value` from the new owner on the same edge.
- Re-granting the same source never pulses `switch_p`.
- Reset at any point: next edge forces IDLE outputs, `last`=3, `hold`=0, prescaler=0, `switch_p`=0.

## Timing
- `req` to `grant` from IDLE: 1 cycle.
- `values` to `value`: 1 cycle.
- Owner drop to new grant: 1 cycle.
- Dwell expiry: the rotation edge is the one following the cycle in which `hold` becomes HOLD_MS while a competitor is requesting.
  - Minimum dwell is HOLD_MS full ticks when grant aligns with a prescaler wrap.
  - Otherwise dwell is up to one tick period shorter.
- Reset values: `value`=16'h0000, `grant`=4'b0000, `blank`=1, `switch_p`=0.
- Simultaneous owner drop and dwell expiry: treated as a drop (rule 2/3); the outcome is identical.

## Configuration
- Macro: `FND_ARB_PREEMPT_EN`.
- Defined:
  - Source 0 is urgent. In SHOW, if `req[0]`=1 and `grant`!=4'b0001, the next edge grants source 0, clears `hold` and pulses `switch_p`.
  - `last` is not updated, so rotation resumes after the interrupted owner once source 0 releases.
  - While source 0 is granted and `req[0]` is high, no rotation occurs, regardless of `hold`.
- Undefined:
  - Source 0 is an ordinary round-robin member.
  - The preempt logic is absent.

## Test plan
Parameters for all scenarios: TICK_DIV=4, HOLD_MS=3.

1. Reset: hold `reset_p` 2 cycles with `req`=4'b1111 -> `grant`=0, `blank`=1, `value`=0. First edge after release -> `grant`=4'b0001, `switch_p`=1 for 1 cycle.
2. Rotation: `req`=4'b0110, `values` word1=16'h1234, word2=16'h5678 -> `grant`=0010 and `value`=1234. Within 3 ticks (≤12 cycles) after grant -> `grant`=0100 and `value`=5678. Then back to 0010.
3. Drop: source 1 owns the display. Drop `req[1]` while `req[3]`=1 -> next edge `grant`=1000, `hold`=0. Drop all requests -> next edge `blank`=1, `value`=0.
4. Live update: source 2 owns the display. Change word2 from 16'h0001 to 16'h0002 -> `value`=0002 one cycle later, with no `switch_p`.
5. Sole requester: `req`=4'b0100 for 40 cycles -> `grant` stays 0100 and `switch_p` never pulses after the first grant.
6. Preempt: macro on; source 2 owns the display and source 3 is requesting. Raise `req[0]` -> next edge `grant`=0001. Drop `req[0]` -> next edge `grant`=1000. Macro off, same stimulus -> `grant` stays 0100 until dwell expiry.
